// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared constants for the multicycle MIPS core.
// Holds the opcode/funct encodings, the FSM state encoding and the datapath width.
package mips_mc_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Sign-extend a 16-bit immediate to the datapath width.
  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] value);
    return {{(DATA_W-16){value[15]}}, value};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two asynchronous read ports,
// one synchronous write port, asynchronous clear. r0 is hardwired to zero.
module mips_regfile
  import mips_mc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [1:31];

  // Storage for r1..r31; writes aimed at r0 are simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset (R-type add/sub/and/or/slt,
// addi, lw, sw, beq, j) with a single request/acknowledge memory port.
// Optional: define MIPS_JAL_EN to add jal (opcode 0x03); otherwise 0x03 is illegal.
module mips_multicycle_core
  import mips_mc_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int RESET_PC     = 0,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              retire,
  output logic              illegal,
  output logic              timeout,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);
  localparam logic [31:0]       WAIT_LAST = 32'(WAIT_TIMEOUT - 1);

  state_t state, next_state;

  logic [ADDR_W-1:0] pc, pc_next;
  logic              pc_we;
  logic [DATA_W-1:0] ir, reg_a, reg_b, imm_ext, alu_out, mdr, alu_res;
  logic              run, timeout_q, set_timeout, funct_ok, wait_expired;
  logic [31:0]       wait_cnt;

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       is_sw;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign is_sw  = (opcode == OP_SW);

  assign wait_expired = (WAIT_TIMEOUT > 0) && (wait_cnt == WAIT_LAST) && !mem_ack;

  mips_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b)
  );

  // ALU: R-type by funct, otherwise A plus the sign-extended immediate.
  always_comb begin
    alu_res  = '0;
    funct_ok = 1'b1;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  alu_res = reg_a + reg_b;
        FN_SUB:  alu_res = reg_a - reg_b;
        FN_AND:  alu_res = reg_a & reg_b;
        FN_OR:   alu_res = reg_a | reg_b;
        FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg_a) < $signed(reg_b))};
        default: funct_ok = 1'b0;
      endcase
    end else begin
      alu_res = reg_a + imm_ext;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus all memory, register-file and status controls.
  always_comb begin
    next_state  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc;
    mem_wdata   = '0;
    retire      = 1'b0;
    illegal     = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = rt;
    rf_wdata    = alu_out;
    pc_we       = 1'b0;
    pc_next     = pc;
    set_timeout = 1'b0;
    case (state)
      FETCH: begin
        mem_req = run;
        if (run && mem_ack) begin
          pc_we      = 1'b1;
          pc_next    = pc + 1'b1;
          next_state = DECODE;
        end else if (run && wait_expired) begin
          set_timeout = 1'b1;
          next_state  = HALT;
        end
      end
      DECODE: begin
        next_state = EXEC;
      end
      EXEC: begin
        next_state = FETCH;
        case (opcode)
          OP_RTYPE: begin
            if (funct_ok) begin
              next_state = WB;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_ADDI: next_state = WB;
          OP_LW, OP_SW: next_state = MEM;
          OP_BEQ: begin
            retire = 1'b1;
            if (reg_a == reg_b) begin
              pc_we   = 1'b1;
              pc_next = pc + imm_ext[ADDR_W-1:0];
            end
          end
          OP_J: begin
            retire  = 1'b1;
            pc_we   = 1'b1;
            pc_next = ir[ADDR_W-1:0];
          end
`ifdef MIPS_JAL_EN
          OP_JAL: begin
            retire   = 1'b1;
            pc_we    = 1'b1;
            pc_next  = ir[ADDR_W-1:0];
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = {{(DATA_W-ADDR_W){1'b0}}, pc};
          end
`else
          OP_JAL: illegal = 1'b1;
`endif
          default: illegal = 1'b1;
        endcase
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        mem_addr  = alu_out[ADDR_W-1:0];
        mem_wdata = is_sw ? reg_b : '0;
        if (mem_ack) begin
          retire     = is_sw;
          next_state = is_sw ? FETCH : WB;
        end else if (wait_expired) begin
          set_timeout = 1'b1;
          next_state  = HALT;
        end
      end
      WB: begin
        rf_we      = 1'b1;
        rf_waddr   = (opcode == OP_RTYPE) ? rd : rt;
        rf_wdata   = (opcode == OP_LW) ? mdr : alu_out;
        retire     = 1'b1;
        next_state = FETCH;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  // Datapath registers: PC, IR, operands, ALU result, memory data, wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= PC_INIT;
      ir        <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      imm_ext   <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      run       <= 1'b0;
      timeout_q <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      run <= 1'b1;
      if (pc_we) begin
        pc <= pc_next;
      end
      if ((state == FETCH) && mem_req && mem_ack) begin
        ir <= mem_rdata;
      end
      if (state == DECODE) begin
        reg_a   <= rf_rdata_a;
        reg_b   <= rf_rdata_b;
        imm_ext <= sext16(ir[15:0]);
      end
      if (state == EXEC) begin
        alu_out <= alu_res;
      end
      if ((state == MEM) && mem_ack && !is_sw) begin
        mdr <= mem_rdata;
      end
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end
      if ((WAIT_TIMEOUT > 0) && mem_req && !mem_ack) begin
        wait_cnt <= wait_cnt + 32'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign timeout   = timeout_q;
  assign dbg_pc    = pc;
  assign dbg_state = state;

endmodule
